parity_check8: RTL and testbench
================================

Name: parity_check8

Overview:
- Receive-side companion to the 8-input XOR parity generator: accepts a byte plus its transmitted parity bit over a valid/ready stream.
- Recomputes parity with an 8-input XOR and forwards the byte with a per-byte error flag.
- Keeps a saturating error counter and a sticky error bit.
- Sits between a link deserializer and the consumer. A 2-entry skid buffer provides full throughput with registered ready.

Parameters:
- ODD, 0, parity sense: 0 = even (a0^..^a7^par must be 0), 1 = odd (must be 1).
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  block can accept; registered.
- in_data  in  8  received byte, bit i = ai.
- in_par  in  1  received parity bit.
- out_valid  out  1  checked byte valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8  forwarded byte, unmodified.
- out_err  out  1  parity mismatch for out_data; qualified by out_valid.
- err_cnt  out  CNT_W  count of accepted bytes with a mismatch; saturating.
- err_seen  out  1  sticky: any mismatch since reset or clear.
- cnt_clr  in  1  synchronous clear of err_cnt and err_seen.

Behaviour:
- Reset values:
  - in_ready=0 during rst; 1 on the first clock after release.
  - out_valid=0, out_data=0, out_err=0, err_cnt=0, err_seen=0.
  - Buffer empty.
- Reset mid-operation discards buffered bytes with no output handshake and leaves counters at 0.
- Accept: in_valid&in_ready at a rising edge.
- Emit: out_valid&out_ready at a rising edge.
- Mismatch per byte: err = ^in_data ^ in_par ^ ODD. Computed at accept and stored with the byte.
- Latency: a byte accepted in cycle N appears on out_* in cycle N+1 when the buffer was empty.
- Buffer: 2 entries (main register plus skid register).
  - States: EMPTY, ONE, FULL.
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & !emit -> FULL.
    - emit & !accept -> EMPTY.
    - accept & emit -> ONE, with the new byte loaded.
  - FULL:
    - emit -> ONE; the skid entry moves to the output.
    - No accept is possible in FULL.
  - in_ready = (state != FULL). It is registered and derived from the next state.
- Ordering is strictly FIFO. No byte is dropped or duplicated.
- out_data and out_err hold stable while out_valid & !out_ready.
- err_cnt increments by 1 on each accepted byte with err=1. It counts at accept, not at emit. It holds at 2^CNT_W-1 when saturated.
- err_seen is set on any accepted byte with err=1.
- cnt_clr together with an erroring accept in the same cycle: err_cnt=1, err_seen=1. The new event wins over the clear.
- cnt_clr alone: err_cnt=0, err_seen=0 next cycle.
- Errors never block flow. Bad bytes are still forwarded, flagged via out_err.
- out_valid depends only on state, never combinationally on in_valid.

Decomposition:
- Shared package parity_pkg:
  - PAR_EVEN=0, PAR_ODD=1 constants.
  - Byte width constant 8.
  - Buffer state typedef {EMPTY, ONE, FULL}.
  - Function par8(byte) returning the XOR reduction. It matches the generator's function exactly.
- One sub-module: parity_skid2. It is a generic 2-entry valid/ready skid buffer of width 9 (data + err).
- The top instantiates parity_skid2 and the counter/sticky logic.

Test Plan:
- Reset then stream 0x00/par0, 0xFF/par0, 0x01/par1, ODD=0, out_ready=1 -> outputs 1 cycle later, one per cycle, all out_err=0, err_cnt=0, in_ready stays 1.
- Byte 0x80 with par=0, ODD=0 -> out_err=1, err_cnt=1, err_seen=1. Same byte with ODD=1 -> out_err=0.
- out_ready=0 while sending 0x11, 0x22, 0x33 -> in_ready drops after 2 accepts. 0x33 waits. Release out_ready -> 0x11, 0x22, 0x33 in order, no loss, out_data stable while stalled.
- CNT_W=2, send 5 bad bytes -> err_cnt goes 1, 2, 3, 3, 3. Then cnt_clr alone -> err_cnt=0, err_seen=0.
- cnt_clr in the same cycle as a bad-byte accept -> err_cnt=1, err_seen=1.
- Assert rst while FULL with out_ready=0 -> out_valid=0 immediately. After release, next byte 0x5A/par0 emerges alone with err_cnt=0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the receive-side parity checker: parity senses, byte width,
// skid-buffer state encoding and the 8-input XOR reduction used by the generator.
package parity_pkg;

  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned BYTE_W   = 8;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } buf_state_e;

  function automatic logic par8(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/parity_skid2.sv
// Generic 2-entry valid/ready skid buffer: main register drives the output, skid register
// absorbs the one extra beat that arrives while ready is still high from the last cycle.
module parity_skid2
  import parity_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q;
  logic         accept, emit;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain path exists.
        if (emit) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

endmodule

// File: rtl/parity_check8.sv
// Receive-side parity checker: flags each accepted byte against its parity bit, forwards it
// through a 2-entry skid buffer, and keeps a saturating error count plus a sticky error bit.
module parity_check8
  import parity_pkg::*;
#(
  parameter int unsigned ODD   = PAR_EVEN,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_seen,
  input  logic              cnt_clr
);

  localparam logic SENSE = (ODD == PAR_ODD);

  logic              in_err;
  logic              accept;
  logic [BYTE_W:0]   out_word;
  logic [CNT_W-1:0]  err_cnt_q;
  logic              err_seen_q;

  assign in_err = par8(in_data) ^ in_par ^ SENSE;
  assign accept = in_valid & in_ready;

  parity_skid2 #(
    .W(BYTE_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({in_err, in_data}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_word)
  );

  assign out_err  = out_word[BYTE_W];
  assign out_data = out_word[BYTE_W-1:0];
  assign err_cnt  = err_cnt_q;
  assign err_seen = err_seen_q;

  // An erroring accept beats a simultaneous clear: the count restarts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q  <= '0;
      err_seen_q <= 1'b0;
    end else if (accept && in_err) begin
      err_seen_q <= 1'b1;
      if (cnt_clr) begin
        err_cnt_q <= CNT_W'(1);
      end else if (err_cnt_q != {CNT_W{1'b1}}) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end else if (cnt_clr) begin
      err_cnt_q  <= '0;
      err_seen_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_check8.sv
// Bench for parity_check8: an even-sense, 2-bit-counter instance and an odd-sense,
// 16-bit-counter instance share all inputs; a scoreboard tracks every byte through.
module tb_parity_check8;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_par = 1'b0;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        in_ready, out_valid, out_err, err_seen;
  logic [7:0]  out_data;
  logic [1:0]  err_cnt;
  logic        in_ready_o, out_valid_o, out_err_o, err_seen_o;
  logic [7:0]  out_data_o;
  logic [15:0] err_cnt_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  parity_check8 #(.ODD(0), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_par(in_par), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_cnt(err_cnt), .err_seen(err_seen), .cnt_clr(cnt_clr)
  );

  parity_check8 #(.ODD(1), .CNT_W(16)) dut_o (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o), .in_data(in_data),
    .in_par(in_par), .out_valid(out_valid_o), .out_ready(out_ready), .out_data(out_data_o),
    .out_err(out_err_o), .err_cnt(err_cnt_o), .err_seen(err_seen_o), .cnt_clr(cnt_clr)
  );

  // Scoreboard: signals are stable mid-cycle and equal what the next rising edge will see.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_emit got data=%02h expected no output", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_data !== e.data || out_err !== e.err || out_err_o !== ~e.err) begin
            errors++;
            $display("FAIL sb_emit got data=%02h err=%b err_odd=%b expected data=%02h err=%b err_odd=%b",
                     out_data, out_err, out_err_o, e.data, e.err, ~e.err);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back('{data: in_data, err: (^in_data) ^ in_par});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0 ||
        err_cnt !== 2'd0 || err_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b data=%02h err=%b cnt=%0d seen=%b expected 0 0 00 0 0 0",
               in_ready, out_valid, out_data, out_err, err_cnt, err_seen);
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_stream();
    logic [7:0] d[3];
    logic       p[3];
    d = '{8'h00, 8'hFF, 8'h01};
    p = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      in_par   = p[i];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== d[i] || out_err !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d got vld=%b data=%02h err=%b rdy=%b expected 1 %02h 0 1",
                 i, out_valid, out_data, out_err, in_ready, d[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || err_cnt !== 2'd0 || err_seen !== 1'b0 ||
        err_cnt_o !== 16'd3 || err_seen_o !== 1'b1) begin
      errors++;
      $display("FAIL stream_counts got vld=%b cnt=%0d seen=%b cnt_odd=%0d seen_odd=%b expected 0 0 0 3 1",
               out_valid, err_cnt, err_seen, err_cnt_o, err_seen_o);
    end
  endtask

  task automatic test_error();
    in_valid = 1'b1;
    in_data  = 8'h80;
    in_par   = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h80 || out_err !== 1'b1 || err_cnt !== 2'd1 ||
        err_seen !== 1'b1 || out_err_o !== 1'b0 || err_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL error_80 got vld=%b data=%02h err=%b cnt=%0d seen=%b err_odd=%b cnt_odd=%0d expected 1 80 1 1 1 0 3",
               out_valid, out_data, out_err, err_cnt, err_seen, out_err_o, err_cnt_o);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [7:0] d[3];
    d = '{8'h11, 8'h22, 8'h33};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = d[i];
      in_par  = ^d[i];
      step();
      checks++;
      if (in_ready !== (i == 0) || out_valid !== 1'b1 || out_data !== 8'h11) begin
        errors++;
        $display("FAIL stall_%0d got rdy=%b vld=%b data=%02h expected rdy=%b vld=1 data=11",
                 i, in_ready, out_valid, out_data, (i == 0));
      end
    end
    step();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL stall_hold got rdy=%b data=%02h expected rdy=0 data=11", in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h22) begin
      errors++;
      $display("FAIL drain_1 got rdy=%b vld=%b data=%02h expected 1 1 22", in_ready, out_valid, out_data);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h33) begin
      errors++;
      $display("FAIL drain_2 got vld=%b data=%02h expected 1 33", out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got vld=%b expected 0", out_valid);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt[5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (err_cnt !== 2'd0 || err_seen !== 1'b0) begin
      errors++;
      $display("FAIL clr_pre got cnt=%0d seen=%b expected 0 0", err_cnt, err_seen);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i * 37 + 3);
      in_par   = ~(^in_data);
      step();
      checks++;
      if (err_cnt !== exp_cnt[i] || err_seen !== 1'b1 || out_err !== 1'b1) begin
        errors++;
        $display("FAIL sat_%0d got cnt=%0d seen=%b err=%b expected %0d 1 1",
                 i, err_cnt, err_seen, out_err, exp_cnt[i]);
      end
    end
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (err_cnt !== 2'd0 || err_seen !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone got cnt=%0d seen=%b expected 0 0", err_cnt, err_seen);
    end
  endtask

  task automatic test_clr_collision();
    in_valid = 1'b1;
    in_data  = 8'h07;
    in_par   = 1'b0;
    step();
    checks++;
    if (err_cnt !== 2'd1) begin
      errors++;
      $display("FAIL collide_pre got cnt=%0d expected 1", err_cnt);
    end
    in_data = 8'h0F;
    in_par  = 1'b1;
    cnt_clr = 1'b1;
    step();
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (err_cnt !== 2'd1 || err_seen !== 1'b1) begin
      errors++;
      $display("FAIL collide got cnt=%0d seen=%b expected 1 1", err_cnt, err_seen);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA1;
    in_par    = 1'b1;
    step();
    in_data = 8'hB2;
    in_par  = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fill got rdy=%b vld=%b expected 0 1", in_ready, out_valid);
    end
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || err_cnt !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid got vld=%b rdy=%b cnt=%0d expected 0 0 0", out_valid, in_ready, err_cnt);
    end
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    in_par    = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_err !== 1'b0 || err_cnt !== 2'd0) begin
      errors++;
      $display("FAIL post_rst got vld=%b data=%02h err=%b cnt=%0d expected 1 5a 0 0",
               out_valid, out_data, out_err, err_cnt);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || err_seen !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_alone got vld=%b seen=%b expected 0 0", out_valid, err_seen);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_error();
    test_backpressure();
    test_saturate();
    test_clr_collision();
    test_reset_mid();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
